// File: rtl/muldiv_sched_if.sv
// Execute-stage handshake bundle for the mul/div scheduler.
// The _i/_o suffixes name each signal's direction as seen from the scheduler.
interface muldiv_sched_if #(
  parameter int XLEN = 32
) ();
  logic            req_valid_i;
  logic            req_ready_o;
  logic [2:0]      req_op_i;
  logic [XLEN-1:0] req_rs1_i;
  logic [XLEN-1:0] req_rs2_i;
  logic            flush_i;
  logic            resp_valid_o;
  logic            resp_ready_i;
  logic [XLEN-1:0] resp_data_o;
  logic            busy_o;

  modport master (
    output req_valid_i, req_op_i, req_rs1_i, req_rs2_i, flush_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_data_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_op_i, req_rs1_i, req_rs2_i, flush_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_data_o, busy_o
  );
endinterface

// File: rtl/muldiv_sched.sv
// Sequences RISC-V M-extension ops onto external fixed-latency multiplier and
// unsigned divider units, with divide special-case bypass and a one-entry result cache.
module muldiv_sched #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33
) (
  input  logic              clk_i,
  input  logic              rst,
  muldiv_sched_if.slave     ex,
  output logic              mul_start_o,
  output logic [XLEN:0]     mul_op1_o,
  output logic [XLEN:0]     mul_op2_o,
  input  logic [2*XLEN+1:0] mul_z_i,
  output logic              div_start_o,
  output logic [XLEN-1:0]   div_dividend_o,
  output logic [XLEN-1:0]   div_divisor_o,
  input  logic [XLEN-1:0]   div_q_i,
  input  logic [XLEN-1:0]   div_r_i,
  output logic              unit_kill_o
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam int CNT_MAX = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] rs1_q, rs2_q, data_q;
  logic            cache_vld_q, cache_sgn_q;
  logic [XLEN-1:0] cache_a_q, cache_b_q, cache_quo_q, cache_rem_q;

  logic            accept, req_sgn, div_zero, div_ovf, cache_hit, bypass;
  logic [XLEN-1:0] bypass_data;
  logic            rs1_neg, rs2_neg, mul_done, div_done;
  logic [XLEN-1:0] quo_fix, rem_fix, mul_res, div_res;
  logic            unused_mul_msbs;

  assign unused_mul_msbs = ^mul_z_i[2*XLEN+1:2*XLEN];

  // Request decode: everything needed to choose a path in the accept cycle.
  always_comb begin
    accept    = ex.req_valid_i & (state_q == S_IDLE) & ~ex.flush_i;
    req_sgn   = ~ex.req_op_i[0];
    div_zero  = (ex.req_rs2_i == '0);
    div_ovf   = req_sgn & (ex.req_rs1_i == MIN_NEG) & (ex.req_rs2_i == '1);
    cache_hit = cache_vld_q & (ex.req_rs1_i == cache_a_q) & (ex.req_rs2_i == cache_b_q)
              & (req_sgn == cache_sgn_q);
    bypass    = ex.req_op_i[2] & (div_zero | div_ovf | cache_hit);
    if (div_zero)     bypass_data = ex.req_op_i[1] ? ex.req_rs1_i : '1;
    else if (div_ovf) bypass_data = ex.req_op_i[1] ? '0 : ex.req_rs1_i;
    else              bypass_data = ex.req_op_i[1] ? cache_rem_q : cache_quo_q;
  end

  // Operand conditioning and result correction from the latched request.
  always_comb begin
    rs1_neg        = ~op_q[0] & rs1_q[XLEN-1];
    rs2_neg        = ~op_q[0] & rs2_q[XLEN-1];
    mul_op1_o      = {~(op_q[1] & op_q[0]) & rs1_q[XLEN-1], rs1_q};
    mul_op2_o      = {~op_q[1] & rs2_q[XLEN-1], rs2_q};
    div_dividend_o = rs1_neg ? -rs1_q : rs1_q;
    div_divisor_o  = rs2_neg ? -rs2_q : rs2_q;
    quo_fix        = (rs1_neg ^ rs2_neg) ? -div_q_i : div_q_i;
    rem_fix        = rs1_neg ? -div_r_i : div_r_i;
    div_res        = op_q[1] ? rem_fix : quo_fix;
    mul_res        = (op_q[1:0] == 2'd0) ? mul_z_i[XLEN-1:0] : mul_z_i[2*XLEN-1:XLEN];
    mul_done       = (state_q == S_MUL) & (cnt_q == MUL_LAST) & ~ex.flush_i;
    div_done       = (state_q == S_DIV) & (cnt_q == DIV_LAST) & ~ex.flush_i;
  end

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    // NOTE: defaulting state_d first keeps every path assigned, so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = !ex.req_op_i[2] ? S_MUL : (bypass ? S_DONE : S_DIV);
      S_MUL:  if (ex.flush_i) state_d = S_IDLE;
              else if (cnt_q == MUL_LAST) state_d = S_DONE;
      S_DIV:  if (ex.flush_i) state_d = S_IDLE;
              else if (cnt_q == DIV_LAST) state_d = S_DONE;
      S_DONE: if (ex.flush_i || ex.resp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ex.req_ready_o  = (state_q == S_IDLE) & ~ex.flush_i;
    ex.busy_o       = (state_q != S_IDLE);
    ex.resp_valid_o = (state_q == S_DONE);
    mul_start_o     = (state_q == S_MUL) & (cnt_q == '0);
    div_start_o     = (state_q == S_DIV) & (cnt_q == '0);
    unit_kill_o     = ex.flush_i & ((state_q == S_MUL) | (state_q == S_DIV));
  end

  assign ex.resp_data_o = data_q;

  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      op_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      data_q      <= '0;
      cache_vld_q <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q <= '0;
        op_q  <= ex.req_op_i;
        rs1_q <= ex.req_rs1_i;
        rs2_q <= ex.req_rs2_i;
        if (bypass) data_q <= bypass_data;
      end else if ((state_q == S_MUL) || (state_q == S_DIV)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (mul_done) data_q <= mul_res;
      if (div_done) begin
        data_q      <= div_res;
        cache_vld_q <= 1'b1;
      end
    end
  end

  // NOTE: the cache payload has no reset; cache_vld_q alone qualifies it.
  always_ff @(posedge clk_i) begin
    if (div_done) begin
      cache_a_q   <= rs1_q;
      cache_b_q   <= rs2_q;
      cache_sgn_q <= ~op_q[0];
      cache_quo_q <= quo_fix;
      cache_rem_q <= rem_fix;
    end
  end

endmodule

// File: tb/tb_muldiv_sched.sv
// Randomized plus directed bench for muldiv_sched, with behavioural mul/div units
// and an arithmetic reference model of results, latencies and the divide cache.
module tb_muldiv_sched;

  localparam int XLEN  = 32;
  localparam int MUL_C = 2;
  localparam int DIV_C = 33;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic clk_i = 1'b0;
  logic rst;

  muldiv_sched_if #(.XLEN(XLEN)) ex ();

  logic              mul_start_o, div_start_o, unit_kill_o;
  logic [XLEN:0]     mul_op1_o, mul_op2_o;
  logic [2*XLEN+1:0] mul_z_i;
  logic [XLEN-1:0]   div_dividend_o, div_divisor_o, div_q_i, div_r_i;

  muldiv_sched #(.XLEN(XLEN), .MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
    .clk_i          (clk_i),
    .rst            (rst),
    .ex             (ex),
    .mul_start_o    (mul_start_o),
    .mul_op1_o      (mul_op1_o),
    .mul_op2_o      (mul_op2_o),
    .mul_z_i        (mul_z_i),
    .div_start_o    (div_start_o),
    .div_dividend_o (div_dividend_o),
    .div_divisor_o  (div_divisor_o),
    .div_q_i        (div_q_i),
    .div_r_i        (div_r_i),
    .unit_kill_o    (unit_kill_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural units: results are only valid in the final cycle of their latency.
  int mul_age = 1000000;
  int div_age = 1000000;
  always @(posedge clk_i) begin
    mul_age <= mul_start_o ? 1 : mul_age + 1;
    div_age <= div_start_o ? 1 : div_age + 1;
  end

  logic signed [2*XLEN+1:0] mul_prod;
  assign mul_prod = $signed(mul_op1_o) * $signed(mul_op2_o);
  assign mul_z_i  = (mul_age == MUL_C - 1) ? mul_prod : '1;
  assign div_q_i  = (div_age == DIV_C - 1) ?
                    ((div_divisor_o != 0) ? div_dividend_o / div_divisor_o : '1) : 32'hA5A5_5A5A;
  assign div_r_i  = (div_age == DIV_C - 1) ?
                    ((div_divisor_o != 0) ? div_dividend_o % div_divisor_o : div_dividend_o) : 32'h5A5A_A5A5;

  int vectors = 0;
  int miscompares = 0;

  // Model of the divide cache: operands of the last op that really used the divider.
  bit          c_vld = 1'b0;
  bit          c_sgn;
  logic [31:0] c_a, c_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned up;
    logic [63:0]     p;
    bit              ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = (a == MIN_NEG) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin sp = sa * sb; p = sp; return p[31:0]; end
      3'd1: begin sp = sa * sb; p = sp; return p[63:32]; end
      3'd2: begin sp = sa * longint'({32'd0, b}); p = sp; return p[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; p = up; return p[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (ovf) return a;
        sp = sa / sb; return sp[31:0];
      end
      3'd5: return (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return '0;
        sp = sa % sb; return sp[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // One full transaction: accept, follow the unit, hold in DONE, then release.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input int hold, input bit flush_end);
    logic [31:0] exp_d;
    int exp_lat, lat, n_ms, n_ds, ms_at, ds_at;
    bit sgn, uses_div;
    exp_d    = ref_result(op, a, b);
    sgn      = !op[0];
    uses_div = 1'b0;
    if (!op[2]) exp_lat = 1 + MUL_C;
    else if (b == 0 || (sgn && a == MIN_NEG && b == 32'hFFFF_FFFF) ||
             (c_vld && c_a == a && c_b == b && c_sgn == sgn)) exp_lat = 1;
    else begin exp_lat = 1 + DIV_C; uses_div = 1'b1; end

    ex.req_valid_i = 1'b1;
    ex.req_op_i    = op;
    ex.req_rs1_i   = a;
    ex.req_rs2_i   = b;
    #1;
    check({tag, " req_ready"}, ex.req_ready_o, 1'b1);
    tick();
    ex.req_valid_i = 1'b0;
    ex.req_op_i    = 3'($urandom);
    ex.req_rs1_i   = $urandom;
    ex.req_rs2_i   = $urandom;

    lat = 0; n_ms = 0; n_ds = 0; ms_at = 0; ds_at = 0;
    for (int k = 1; k <= DIV_C + 4; k++) begin
      #1;
      if (mul_start_o) begin n_ms++; if (ms_at == 0) ms_at = k; end
      if (div_start_o) begin n_ds++; if (ds_at == 0) ds_at = k; end
      if (ex.resp_valid_o) begin lat = k; break; end
      tick();
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " data"}, ex.resp_data_o, exp_d);
    check({tag, " mul starts"}, n_ms, op[2] ? 0 : 1);
    check({tag, " div starts"}, n_ds, uses_div ? 1 : 0);
    if (!op[2]) check({tag, " mul start cycle"}, ms_at, 1);
    if (uses_div) check({tag, " div start cycle"}, ds_at, 1);

    for (int j = 0; j < hold; j++) begin
      ex.req_valid_i = 1'b1;
      tick();
      #1;
      check({tag, " hold valid"}, ex.resp_valid_o, 1'b1);
      check({tag, " hold data"}, ex.resp_data_o, exp_d);
      check({tag, " hold req_ready"}, ex.req_ready_o, 1'b0);
    end
    ex.req_valid_i  = 1'b0;
    ex.resp_ready_i = 1'b1;
    ex.flush_i      = flush_end;
    #1;
    check({tag, " req_ready in final DONE"}, ex.req_ready_o, 1'b0);
    tick();
    ex.resp_ready_i = 1'b0;
    ex.flush_i      = 1'b0;
    #1;
    check({tag, " resp_valid dropped"}, ex.resp_valid_o, 1'b0);
    check({tag, " idle busy"}, ex.busy_o, 1'b0);
    check({tag, " idle req_ready"}, ex.req_ready_o, 1'b1);
    if (uses_div) begin c_vld = 1'b1; c_a = a; c_b = b; c_sgn = sgn; end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete (%0d vectors, %0d miscompares)",
             vectors, miscompares);
    $fatal(1);
  end

  initial begin : stim
    logic [2:0]  op;
    logic [31:0] a, b, prev_a, prev_b, r;
    int          mode, resp_seen;

    rst             = 1'b0;
    ex.req_valid_i  = 1'b0;
    ex.req_op_i     = '0;
    ex.req_rs1_i    = '0;
    ex.req_rs2_i    = '0;
    ex.flush_i      = 1'b0;
    ex.resp_ready_i = 1'b0;
    tick();
    #1;
    check("reset req_ready", ex.req_ready_o, 1'b1);
    check("reset busy", ex.busy_o, 1'b0);
    check("reset resp_valid", ex.resp_valid_o, 1'b0);
    check("reset resp_data", ex.resp_data_o, 32'd0);
    check("reset mul_start", mul_start_o, 1'b0);
    check("reset div_start", div_start_o, 1'b0);
    check("reset unit_kill", unit_kill_o, 1'b0);
    tick();
    rst = 1'b1;
    tick();

    // Multiply high-half signedness.
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh -1*-1", 0, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu max*max", 0, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu -1*max", 0, 1'b0);
    run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, "mul low", 0, 1'b0);

    // Signed divide, then the matching remainder from the cache.
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div -7/2", 0, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem -7,2 cached", 0, 1'b0);

    // Divide special cases.
    run_op(3'd5, 32'd5, 32'd0, "divu 5/0", 0, 1'b0);
    run_op(3'd7, 32'd5, 32'd0, "remu 5/0", 0, 1'b0);
    run_op(3'd4, MIN_NEG, 32'hFFFF_FFFF, "div overflow", 0, 1'b0);
    run_op(3'd6, MIN_NEG, 32'hFFFF_FFFF, "rem overflow", 0, 1'b0);
    run_op(3'd4, 32'd9, 32'd0, "div signed by zero", 0, 1'b0);

    // Flush in IDLE blocks acceptance.
    ex.flush_i     = 1'b1;
    ex.req_valid_i = 1'b1;
    ex.req_op_i    = 3'd0;
    #1;
    check("idle flush req_ready", ex.req_ready_o, 1'b0);
    tick();
    ex.flush_i     = 1'b0;
    ex.req_valid_i = 1'b0;
    #1;
    check("idle flush not accepted", ex.busy_o, 1'b0);

    // Flush ten cycles into a divide.
    ex.req_valid_i = 1'b1;
    ex.req_op_i    = 3'd4;
    ex.req_rs1_i   = 32'd100;
    ex.req_rs2_i   = 32'd7;
    #1;
    check("flush div accepted", ex.req_ready_o, 1'b1);
    tick();
    ex.req_valid_i = 1'b0;
    repeat (9) tick();
    ex.flush_i = 1'b1;
    #1;
    check("flush unit_kill", unit_kill_o, 1'b1);
    check("flush busy before", ex.busy_o, 1'b1);
    tick();
    ex.flush_i = 1'b0;
    #1;
    check("flush idle busy", ex.busy_o, 1'b0);
    check("flush kill one cycle", unit_kill_o, 1'b0);
    check("flush idle req_ready", ex.req_ready_o, 1'b1);
    resp_seen = 0;
    repeat (DIV_C + 2) begin
      tick();
      if (ex.resp_valid_o) resp_seen++;
    end
    check("flush no response", resp_seen, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "cache kept after flush", 0, 1'b0);
    run_op(3'd4, 32'd100, 32'd7, "flushed op not cached", 0, 1'b0);

    // Backpressure and flush-over-ready in DONE.
    run_op(3'd0, 32'd6, 32'd7, "backpressure", 5, 1'b0);
    run_op(3'd3, 32'hDEAD_BEEF, 32'h0000_1000, "flush beats ready", 0, 1'b1);

    // Randomized mix, biased towards divide corner cases and cache reuse.
    prev_a = 32'd1;
    prev_b = 32'd1;
    for (int i = 0; i < 40; i++) begin
      op   = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 4);
      a    = $urandom;
      b    = $urandom;
      case (mode)
        1: begin
          r = $urandom; a = {{24{r[7]}}, r[7:0]};
          r = $urandom; b = {{24{r[15]}}, r[15:8]};
        end
        2: b = 32'd0;
        3: begin a = MIN_NEG; b = 32'hFFFF_FFFF; end
        4: begin a = prev_a; b = prev_b; end
        default: ;
      endcase
      run_op(op, a, b, "random", 0, 1'b0);
      prev_a = a;
      prev_b = b;
    end

    // Asynchronous reset in the middle of a divide.
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div before reset", 0, 1'b0);
    ex.req_valid_i = 1'b1;
    ex.req_op_i    = 3'd4;
    ex.req_rs1_i   = 32'hFFFF_FC18;
    ex.req_rs2_i   = 32'd3;
    #1;
    tick();
    ex.req_valid_i = 1'b0;
    repeat (4) tick();
    check("pre-reset dividend", div_dividend_o, 32'd1000);
    rst = 1'b0;
    #1;
    check("async reset busy", ex.busy_o, 1'b0);
    check("async reset req_ready", ex.req_ready_o, 1'b1);
    check("async reset resp_valid", ex.resp_valid_o, 1'b0);
    check("async reset resp_data", ex.resp_data_o, 32'd0);
    check("async reset dividend", div_dividend_o, 32'd0);
    check("async reset div_start", div_start_o, 1'b0);
    check("async reset unit_kill", unit_kill_o, 1'b0);
    check("async reset mul_op1", mul_op1_o, 33'd0);
    tick();
    tick();
    rst   = 1'b1;
    c_vld = 1'b0;
    resp_seen = 0;
    repeat (DIV_C + 3) begin
      tick();
      if (ex.resp_valid_o) resp_seen++;
    end
    check("no response after reset", resp_seen, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "cache cleared by reset", 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_sched.md
MULDIV_SCHED -- requirements
Module: muldiv_sched

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter MUL_CYCLES, default 2, fixed multiplier latency in cycles (>=1).
REQ-003 SHALL have parameter DIV_CYCLES, default 33, fixed divider latency in cycles (>=1).
REQ-004 SHALL have port clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req_valid_i in 1 and req_ready_o out 1: request handshake from the execute stage.
REQ-007 SHALL have port req_op_i  in  3  operation: 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu.
REQ-008 SHALL have ports req_rs1_i and req_rs2_i, in, XLEN: operands OP1 and OP2.
REQ-009 SHALL have port flush_i  in  1  kills any in-flight or pending operation.
REQ-010 SHALL have ports mul_start_o out 1, mul_op1_o out XLEN+1, mul_op2_o out XLEN+1, mul_z_i in 2*XLEN+2: multiplier interface.
REQ-011 SHALL have ports div_start_o out 1, div_dividend_o out XLEN, div_divisor_o out XLEN, div_q_i in XLEN, div_r_i in XLEN: unsigned divider interface.
REQ-012 SHALL have port unit_kill_o  out  1  aborts the active unit.
REQ-013 SHALL have ports resp_valid_o out 1, resp_ready_i in 1, resp_data_o out XLEN: result handshake.
REQ-014 SHALL have port busy_o  out  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, MUL, DIV, DONE; req_ready_o = (state==IDLE) & ~flush_i.
REQ-016 SHALL accept a request in cycle T when req_valid_i & req_ready_o, latching op and operands.
REQ-017 SHALL, for ops 0-3, enter MUL and assert mul_start_o for exactly one cycle (T+1), with operands: mul/mulh sign-extend both operands; mulhsu sign-extends OP1 and zero-extends OP2; mulhu zero-extends both.
REQ-018 SHALL, in MUL, count MUL_CYCLES cycles from start, capture mul_z_i in the final cycle and enter DONE, so resp_valid_o rises at T+1+MUL_CYCLES.
REQ-019 SHALL take mul result bits [XLEN-1:0] for op 0, and bits [2*XLEN-1:XLEN] for ops 1-3.
REQ-020 SHALL, for signed div/rem, drive absolute values of OP1/OP2 to the divider; for divu/remu, drive raw operands.
REQ-021 SHALL, in DIV, count DIV_CYCLES cycles from the div_start_o pulse at T+1, capture div_q_i/div_r_i, and enter DONE (resp_valid_o at T+1+DIV_CYCLES).
REQ-022 SHALL sign-correct signed results: quotient negated when sign(OP1)^sign(OP2); remainder negated when sign(OP1).
REQ-023 SHALL bypass the divider (no div_start_o, DONE at T+1) for divisor zero: quotient all-ones, remainder OP1.
REQ-024 SHALL bypass for signed overflow (OP1=0x80000000, OP2=0xFFFFFFFF): quotient OP1, remainder 0.
REQ-025 SHALL keep a one-entry cache of the last completed divider result: dividend, divisor, signedness, quotient, remainder, valid bit.
REQ-026 SHALL bypass to DONE at T+1 using cached values when a div-class request matches cached operands and signedness, e.g. rem following div.
REQ-027 SHALL hold resp_valid_o and resp_data_o stable in DONE until resp_ready_i, then return to IDLE next cycle.
REQ-028 SHALL not accept a new request in the cycle DONE completes; the earliest next acceptance is the following cycle.
REQ-029 SHALL, on flush_i in MUL or DIV, pulse unit_kill_o for one cycle, discard the result, not update the cache, and enter IDLE next cycle.
REQ-030 SHALL, on flush_i in DONE, drop resp_valid_o next cycle and enter IDLE; flush in IDLE blocks acceptance that cycle.
REQ-031 SHALL give flush_i priority over resp_ready_i when both are high in DONE.

Reset
REQ-032 SHALL, on rst low, asynchronously force IDLE, counter 0, cache valid 0, and all outputs 0 except req_ready_o=1.
REQ-033 SHALL abandon any operation active at reset assertion, with no response after release.

Verification
REQ-034 SHALL cover: mulh 0xFFFFFFFF x 0xFFFFFFFF accepted at T -> resp_data_o=0x00000000 at T+3; mulhu same operands -> 0xFFFFFFFE.
REQ-035 SHALL cover: div -7 / 2 -> quotient 0xFFFFFFFD at T+34; then rem -7, 2 -> 0xFFFFFFFF at T'+1 via cache, no div_start_o.
REQ-036 SHALL cover: divu 5/0 -> 0xFFFFFFFF and remu 5/0 -> 5, each at T+1; div 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-037 SHALL cover: flush_i at cycle T+10 of a div -> unit_kill_o pulse, no resp_valid_o, IDLE at T+11, cache unchanged.
REQ-038 SHALL cover: resp_ready_i held low 5 cycles in DONE -> data stable, req_ready_o low throughout; rst low mid-DIV -> all outputs reset immediately.
